stupidrv_mem: RTL

Memory responder for the stupidrv core: serves the core's instruction-fetch port and data port from one shared word-addressed RAM, and drives the core's `stall` input to insert data-access wait states. It also holds an optional memory-mapped I/O window: a console byte output and a free-running cycle counter. It sits directly beside the core in simulation and FPGA test tops, with the core as the only initiator.

---
 rtl/stupidrv_mem.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/stupidrv_mem.sv
// stupidrv_mem: memory responder for the stupidrv core.
//
// One word-addressed RAM serves both the instruction-fetch port and the
// data port. The fetch port reads every cycle the core is not held. The
// data port runs through a small FSM (IDLE -> [WAIT] -> RESP) that inserts
// DMEM_WAIT extra wait states and holds the core through `stall`.
//
// Compile-time option:
//   STUPIDRV_MEM_IO_EN  - enables an 8-byte I/O window at IO_ADDR:
//                         +0 write: console byte strobe (io_valid/io_data)
//                         +0 read : returns 0
//                         +4 read : free-running 32-bit cycle counter
//                         Without it, IO_ADDR is ordinary RAM, io_* are 0
//                         and the cycle counter does not exist.
//
// Data port handshake: the core raises dmem_valid with address, strobes and
// write data, and keeps all of them stable while stall=1. `stall` is the
// inverse of ready: the cycle in which stall=0 with dmem_valid=1 is the
// response cycle (RESP). Read data is valid in that cycle and any write
// commits on the edge that ends it.
//
// o_dbg_state exposes the data FSM state (0=IDLE, 1=WAIT, 2=RESP).

module stupidrv_mem #(
   parameter int          MEM_WORDS = 4096,
   parameter string       MEM_INIT  = "",
   parameter int          DMEM_WAIT = 0,
   parameter logic [31:0] IO_ADDR   = 32'h1000_0000
) (
   input  logic        clock,
   input  logic        resetn,
   output logic        stall,
   input  logic [31:0] imem_addr,
   output logic [31:0] imem_data,
   input  logic        dmem_valid,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_wstrb,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        io_valid,
   output logic [7:0]  io_data,
   output logic [1:0]  o_dbg_state
);

   localparam int AW = $clog2(MEM_WORDS);

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Storage: contents are deliberately not reset.
   logic [31:0] r_mem [MEM_WORDS];

   // ---------------------------------------------------------------------
   // Address decode. High address bits are ignored, so addresses alias
   // modulo the RAM size.
   // ---------------------------------------------------------------------
   logic [AW-1:0] w_iidx;
   logic [AW-1:0] w_didx;

   assign w_iidx = imem_addr[AW+1:2];
   assign w_didx = dmem_addr[AW+1:2];

   // Bits that do not take part in any decode.
   logic w_unused;
   assign w_unused = &{1'b0, imem_addr[31:AW+2], imem_addr[1:0],
                       dmem_addr[31:AW+2], dmem_addr[1:0]};

   // ---------------------------------------------------------------------
   // Data FSM
   // ---------------------------------------------------------------------
   state_t     r_state;
   state_t     w_next_state;
   logic [3:0] r_wait_cnt;
   logic [3:0] w_next_cnt;
   logic       w_capture;   // edge entering RESP: latch read data
   logic       w_commit;    // edge leaving RESP: write takes effect

   // State and wait-counter register; reset abandons any pending access.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state    <= ST_IDLE;
         r_wait_cnt <= 4'd0;
      end else begin
         r_state    <= w_next_state;
         r_wait_cnt <= w_next_cnt;
      end
   end

   // Next-state logic: counts wait states, drops back to IDLE if the
   // request disappears while waiting, and flags capture/commit edges.
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_wait_cnt;
      w_capture    = 1'b0;
      w_commit     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (dmem_valid) begin
               w_next_cnt = 4'(DMEM_WAIT);
               if (DMEM_WAIT > 0) begin
                  w_next_state = ST_WAIT;
               end else begin
                  w_next_state = ST_RESP;
                  w_capture    = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (!dmem_valid) begin
               // Abandoned: nothing was written, nothing is captured.
               w_next_state = ST_IDLE;
            end else if (r_wait_cnt == 4'd1) begin
               w_next_state = ST_RESP;
               w_capture    = 1'b1;
            end else begin
               w_next_cnt = r_wait_cnt - 4'd1;
            end
         end
         ST_RESP: begin
            w_next_state = ST_IDLE;
            w_commit     = (dmem_wstrb != 4'b0000);
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Hold the core whenever a request is pending and not being answered.
   assign stall       = dmem_valid && (r_state != ST_RESP);
   assign o_dbg_state = r_state;

   // ---------------------------------------------------------------------
   // I/O window and cycle counter
   // ---------------------------------------------------------------------
   logic        w_io_hit;   // data address falls in the 8-byte window
   logic [31:0] w_io_rdata;

`ifdef STUPIDRV_MEM_IO_EN
   logic [31:0] r_cycles;

   assign w_io_hit   = ({dmem_addr[31:3], 3'b000} == IO_ADDR);
   assign w_io_rdata = dmem_addr[2] ? r_cycles : 32'h0000_0000;

   // Free-running cycle counter; wraps naturally at 32 bits.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_cycles <= 32'h0000_0000;
      end else begin
         r_cycles <= r_cycles + 32'd1;
      end
   end

   // Console strobe: one cycle after a committed byte-0 write to +0.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         io_valid <= 1'b0;
         io_data  <= 8'h00;
      end else begin
         io_valid <= w_commit && w_io_hit && !dmem_addr[2] && dmem_wstrb[0];
         if (w_commit && w_io_hit && !dmem_addr[2] && dmem_wstrb[0]) begin
            io_data <= dmem_wdata[7:0];
         end
      end
   end
`else
   assign w_io_hit   = 1'b0;
   assign w_io_rdata = 32'h0000_0000;
   assign io_valid   = 1'b0;
   assign io_data    = 8'h00;
`endif

   // ---------------------------------------------------------------------
   // RAM ports
   // ---------------------------------------------------------------------
   logic w_ram_we;
   assign w_ram_we = w_commit && !w_io_hit;

   // Byte-lane write; lane i carries dmem_wdata byte i.
   always_ff @(posedge clock) begin
      if (w_ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (dmem_wstrb[i]) begin
               r_mem[w_didx][8*i +: 8] <= dmem_wdata[8*i +: 8];
            end
         end
      end
   end

   // Fetch port: registered read, frozen while the core is held. Reads
   // the pre-write value when a store commits on the same edge.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         imem_data <= NOP_INSN;
      end else if (!stall) begin
         imem_data <= r_mem[w_iidx];
      end
   end

   // Data read capture on the edge entering RESP; held until the next one.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         dmem_rdata <= 32'h0000_0000;
      end else if (w_capture) begin
         dmem_rdata <= w_io_hit ? w_io_rdata : r_mem[w_didx];
      end
   end

endmodule
